// File: rtl/mult_ctrl.sv
// rtl/mult_ctrl.sv - sequencing controller between the pipeline and an iterative multiplier
module mult_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [4:0]  tag_in_i,
  input  logic        flush_i,
  output logic        mult_enable_o,
  output logic [31:0] mult_multiplicand_o,
  output logic [31:0] mult_multiplier_o,
  input  logic        mult_ready_i,
  input  logic [31:0] mult_result_i,
  input  logic        mult_exception_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        exception_o,
  output logic        timeout_err_o,
  output logic [4:0]  tag_out_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [5:0] TIMEOUT_CNT = 6'(TIMEOUT);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [4:0]  tag_q, tag_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic [4:0]  tag_out_q, tag_out_d;

  logic accept;
  logic ready_ok;
  logic timeout_hit;
  logic capture;

  // A ready seen on the first BUSY cycle may belong to the previous operation.
  assign accept      = (state_q == S_IDLE) && req_i && !flush_i;
  assign ready_ok    = mult_ready_i && (cnt_q != 6'd0);
  assign timeout_hit = (cnt_q == TIMEOUT_CNT);
  assign capture     = (state_q == S_BUSY) && ready_ok && !flush_i;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: state_d = flush_i ? S_IDLE : S_BUSY;
      S_BUSY: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (ready_ok) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mult_enable_o = (state_q == S_START);
    stall_o       = (state_q == S_START) || (state_q == S_BUSY) || accept;
    done_o        = (state_q == S_DONE) && !flush_i;
    timeout_err_o = (state_q == S_BUSY) && timeout_hit && !ready_ok && !flush_i;
  end

  always_comb begin
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    exc_d     = exc_q;
    tag_out_d = tag_out_q;
    if (accept) begin
      op_a_d = op_a_i;
      op_b_d = op_b_i;
      tag_d  = tag_in_i;
    end
    if (state_q == S_START) begin
      cnt_d = 6'd0;
    end else if (state_q == S_BUSY && cnt_q != 6'd63) begin
      cnt_d = cnt_q + 6'd1;
    end
    if (capture) begin
      result_d  = mult_result_i;
      exc_d     = mult_exception_i;
      tag_out_d = tag_q;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      op_a_q    <= 32'd0;
      op_b_q    <= 32'd0;
      tag_q     <= 5'd0;
      cnt_q     <= 6'd0;
      result_q  <= 32'd0;
      exc_q     <= 1'b0;
      tag_out_q <= 5'd0;
    end else begin
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      tag_out_q <= tag_out_d;
    end
  end

  assign mult_multiplicand_o = op_a_q;
  assign mult_multiplier_o   = op_b_q;
  assign result_o            = result_q;
  assign exception_o         = exc_q;
  assign tag_out_o           = tag_out_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// tb/tb_mult_ctrl.sv - self-checking bench for mult_ctrl with a behavioural multiplier model
module tb_mult_ctrl;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        req_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [4:0]  tag_in_i;
  logic        flush_i;
  logic        mult_enable_o;
  logic [31:0] mult_multiplicand_o;
  logic [31:0] mult_multiplier_o;
  logic        mult_ready_i;
  logic [31:0] mult_result_i;
  logic        mult_exception_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        exception_o;
  logic        timeout_err_o;
  logic [4:0]  tag_out_o;

  mult_ctrl #(.TIMEOUT(40)) dut (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .req_i              (req_i),
    .op_a_i             (op_a_i),
    .op_b_i             (op_b_i),
    .tag_in_i           (tag_in_i),
    .flush_i            (flush_i),
    .mult_enable_o      (mult_enable_o),
    .mult_multiplicand_o(mult_multiplicand_o),
    .mult_multiplier_o  (mult_multiplier_o),
    .mult_ready_i       (mult_ready_i),
    .mult_result_i      (mult_result_i),
    .mult_exception_i   (mult_exception_i),
    .stall_o            (stall_o),
    .done_o             (done_o),
    .result_o           (result_o),
    .exception_o        (exception_o),
    .timeout_err_o      (timeout_err_o),
    .tag_out_o          (tag_out_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    int          lat;
    logic [31:0] res;
    logic        exc;
    logic [4:0]  tag_out;
    bit          to;
  } vec_t;

  int checks = 0;
  int errors = 0;

  bit          m_auto = 1'b0;
  int          m_lat  = 0;
  int          m_cnt  = 0;
  bit          m_busy = 1'b0;
  logic [31:0] m_a, m_b;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Multiplier model: one-cycle ready m_lat cycles after the enable cycle; lat 0 = never.
  task automatic model_update();
    longint p;
    if (m_auto) begin
      mult_ready_i = 1'b0;
      if (mult_enable_o) begin
        m_busy = (m_lat > 0);
        m_cnt  = m_lat;
        m_a    = mult_multiplicand_o;
        m_b    = mult_multiplier_o;
      end else if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          p = longint'($signed(m_a)) * longint'($signed(m_b));
          mult_ready_i     = 1'b1;
          mult_result_i    = p[31:0];
          mult_exception_i = (p != longint'($signed(p[31:0])));
          m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
    model_update();
    #1;
  endtask

  task automatic run_op(input vec_t v);
    int cyc;
    int enables;
    int bad_stall;
    m_auto   = 1'b1;
    m_lat    = v.lat;
    op_a_i   = v.a;
    op_b_i   = v.b;
    tag_in_i = v.tag;
    req_i    = 1'b1;
    #1;
    chk1("req_cycle_stall", stall_o, 1'b1);
    chk1("req_cycle_enable", mult_enable_o, 1'b0);
    tick();
    req_i  = 1'b0;
    op_a_i = ~v.a;
    op_b_i = ~v.b;
    #1;
    chk1("start_enable", mult_enable_o, 1'b1);
    chk32("start_multiplicand", mult_multiplicand_o, v.a);
    chk32("start_multiplier", mult_multiplier_o, v.b);
    cyc = 0;
    enables = 1;
    bad_stall = 0;
    while (!(done_o || timeout_err_o) && cyc < 60) begin
      tick();
      cyc++;
      if (mult_enable_o) enables++;
      if (!done_o && !stall_o) bad_stall++;
    end
    if (v.to) begin
      chk1("timeout_pulse", timeout_err_o, 1'b1);
      chk32("timeout_cycle", cyc, 32'd41);
      chk1("timeout_no_done", done_o, 1'b0);
    end else begin
      chk1("done_pulse", done_o, 1'b1);
      chk32("done_latency", cyc, v.lat + 1);
      chk1("done_stall_low", stall_o, 1'b0);
      chk32("done_multiplicand_stable", mult_multiplicand_o, v.a);
    end
    chk32("result", result_o, v.res);
    chk1("exception", exception_o, v.exc);
    chk32("tag_out", 32'(tag_out_o), 32'(v.tag_out));
    chk32("enable_pulses", enables, 32'd1);
    chk32("stall_gaps", bad_stall, 32'd0);
    tick();
    chk1("after_done", done_o, 1'b0);
    chk1("after_timeout_err", timeout_err_o, 1'b0);
    chk1("after_stall", stall_o, 1'b0);
    tick();
    chk1("idle_stale_ready_ignored", done_o, 1'b0);
    chk1("idle_stall", stall_o, 1'b0);
  endtask

  vec_t vecs[8];

  initial begin
    int dones;
    int bad;
    vecs[0] = '{32'd7,          32'd6,          5'd3,  33, 32'd42,         1'b0, 5'd3,  1'b0};
    vecs[1] = '{32'h7FFF_FFFF,  32'd2,          5'd5,  5,  32'hFFFF_FFFE,  1'b1, 5'd5,  1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd31, 2,  32'd1,          1'b0, 5'd31, 1'b0};
    vecs[3] = '{32'h0001_0000,  32'h0001_0000,  5'd7,  2,  32'd0,          1'b1, 5'd7,  1'b0};
    vecs[4] = '{32'h0000_0400,  32'h0000_0400,  5'd20, 40, 32'h0010_0000,  1'b0, 5'd20, 1'b0};
    vecs[5] = '{32'd3,          32'hFFFF_FFFB,  5'd9,  41, 32'hFFFF_FFF1,  1'b0, 5'd9,  1'b0};
    vecs[6] = '{32'd100,        32'd100,        5'd12, 42, 32'hFFFF_FFF1,  1'b0, 5'd9,  1'b1};
    vecs[7] = '{32'h1234_5678,  32'h0000_0010,  5'd4,  0,  32'hFFFF_FFF1,  1'b0, 5'd9,  1'b1};

    reset_i = 1'b1;
    req_i = 1'b0;
    flush_i = 1'b0;
    op_a_i = '0;
    op_b_i = '0;
    tag_in_i = '0;
    mult_ready_i = 1'b0;
    mult_result_i = '0;
    mult_exception_i = 1'b0;
    #2;
    chk1("reset_stall", stall_o, 1'b0);
    chk1("reset_done", done_o, 1'b0);
    chk1("reset_enable", mult_enable_o, 1'b0);
    chk32("reset_result", result_o, 32'd0);
    chk32("reset_tag_out", 32'(tag_out_o), 32'd0);
    chk32("reset_multiplicand", mult_multiplicand_o, 32'd0);
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    chk1("post_reset_stall", stall_o, 1'b0);

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Stale ready held through START and the first BUSY cycle.
    m_auto = 1'b0;
    mult_ready_i = 1'b1;
    mult_result_i = 32'h0000_1234;
    mult_exception_i = 1'b0;
    op_a_i = 32'd2;
    op_b_i = 32'd3;
    tag_in_i = 5'd1;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    #1;
    chk1("stale_start_enable", mult_enable_o, 1'b1);
    tick();
    chk1("stale_busy0_no_done", done_o, 1'b0);
    chk1("stale_busy0_stall", stall_o, 1'b1);
    tick();
    chk1("stale_busy1_no_done", done_o, 1'b0);
    tick();
    chk1("stale_capture_done", done_o, 1'b1);
    chk32("stale_capture_result", result_o, 32'h0000_1234);
    chk32("stale_capture_tag", 32'(tag_out_o), 32'd1);
    mult_ready_i = 1'b0;
    tick();
    chk1("stale_idle", stall_o, 1'b0);

    // Flush at BUSY counter 10, with a ready arriving later.
    m_auto = 1'b1;
    m_lat = 20;
    op_a_i = 32'd5;
    op_b_i = 32'd5;
    tag_in_i = 5'd2;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    for (int k = 0; k < 11; k++) tick();
    flush_i = 1'b1;
    #1;
    chk1("flush_busy_no_done", done_o, 1'b0);
    chk1("flush_busy_no_timeout", timeout_err_o, 1'b0);
    tick();
    flush_i = 1'b0;
    #1;
    chk1("flush_idle_stall", stall_o, 1'b0);
    chk1("flush_idle_enable", mult_enable_o, 1'b0);
    dones = 0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done_o) dones++;
      if (stall_o) bad++;
    end
    chk32("flush_late_ready_done", dones, 32'd0);
    chk32("flush_late_ready_stall", bad, 32'd0);
    chk32("flush_result_held", result_o, 32'h0000_1234);
    run_op('{32'h7FFF_FFFF, 32'd2, 5'd6, 4, 32'hFFFF_FFFE, 1'b1, 5'd6, 1'b0});

    // Back-to-back with req held high.
    m_lat = 3;
    op_a_i = 32'd11;
    op_b_i = 32'd13;
    tag_in_i = 5'd10;
    req_i = 1'b1;
    tick();
    chk1("b2b_first_enable", mult_enable_o, 1'b1);
    bad = 0;
    while (!done_o && bad < 20) begin
      tick();
      bad++;
    end
    chk1("b2b_first_done", done_o, 1'b1);
    chk32("b2b_first_result", result_o, 32'd143);
    op_a_i = 32'h20;
    op_b_i = 32'h30;
    tag_in_i = 5'd11;
    #1;
    chk1("b2b_done_stall", stall_o, 1'b0);
    chk1("b2b_done_enable", mult_enable_o, 1'b0);
    tick();
    chk1("b2b_idle_done_low", done_o, 1'b0);
    chk1("b2b_idle_stall", stall_o, 1'b1);
    chk1("b2b_idle_enable", mult_enable_o, 1'b0);
    chk32("b2b_idle_multiplicand", mult_multiplicand_o, 32'd11);
    tick();
    req_i = 1'b0;
    chk1("b2b_second_enable", mult_enable_o, 1'b1);
    chk32("b2b_second_multiplicand", mult_multiplicand_o, 32'h20);
    chk32("b2b_second_multiplier", mult_multiplier_o, 32'h30);
    bad = 0;
    while (!done_o && bad < 20) begin
      tick();
      bad++;
    end
    chk1("b2b_second_done", done_o, 1'b1);
    chk32("b2b_second_result", result_o, 32'h600);
    chk32("b2b_second_tag", 32'(tag_out_o), 32'd11);
    tick();

    // Asynchronous reset in the middle of BUSY.
    m_lat = 10;
    op_a_i = 32'd9;
    op_b_i = 32'd9;
    tag_in_i = 5'd13;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #1;
    reset_i = 1'b1;
    #1;
    chk1("arst_stall", stall_o, 1'b0);
    chk1("arst_done", done_o, 1'b0);
    chk1("arst_enable", mult_enable_o, 1'b0);
    chk1("arst_timeout", timeout_err_o, 1'b0);
    chk1("arst_exception", exception_o, 1'b0);
    chk32("arst_result", result_o, 32'd0);
    chk32("arst_tag_out", 32'(tag_out_o), 32'd0);
    chk32("arst_multiplicand", mult_multiplicand_o, 32'd0);
    chk32("arst_multiplier", mult_multiplier_o, 32'd0);
    tick();
    reset_i = 1'b0;
    dones = 0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done_o) dones++;
      if (stall_o) bad++;
    end
    chk32("arst_no_done_after", dones, 32'd0);
    chk32("arst_idle_after", bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
